// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared fixed-point constants and saturation helper for the multiplier chain
package mult_pkg;

    // Default product word width, signed Q1.(NB_DATA-1)
    localparam int NB_DATA_DEF = 4;

    // Largest and smallest representable Q1.(NB_DATA_DEF-1) words
    localparam logic signed [NB_DATA_DEF-1:0] QMAX = {1'b0, {(NB_DATA_DEF-1){1'b1}}};
    localparam logic signed [NB_DATA_DEF-1:0] QMIN = {1'b1, {(NB_DATA_DEF-1){1'b0}}};

    // True when a sign-extended sum falls outside the Q1.(nb_data-1) range
    function automatic logic saturate_ovf(input logic signed [31:0] sum, input int nb_data);
        logic signed [31:0] qmax;
        logic signed [31:0] qmin;
        qmax = (32'sd1 <<< (nb_data - 1)) - 32'sd1;
        qmin = -qmax - 32'sd1;
        return (sum > qmax) || (sum < qmin);
    endfunction

endpackage

// File: rtl/sat_q.sv
// rtl/sat_q.sv - combinational saturator from guard-extended sum to Q1.(NB_DATA-1)
import mult_pkg::*;

module sat_q #(
    parameter int NB_DATA = 4,
    parameter int NB_ACC  = 7
) (
    input  logic signed [NB_ACC-1:0]  sum,
    output logic        [NB_DATA-1:0] sat,
    output logic                      ovf
);

    localparam logic [NB_DATA-1:0] SAT_MAX = {1'b0, {(NB_DATA-1){1'b1}}};
    localparam logic [NB_DATA-1:0] SAT_MIN = {1'b1, {(NB_DATA-1){1'b0}}};

    // Clamp to the rail matching the sign of the sum, else pass the low bits through
    always_comb begin
        ovf = saturate_ovf(32'(sum), NB_DATA);
        sat = sum[NB_DATA-1:0];
        if (ovf) begin
            sat = sum[NB_ACC-1] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/mult_acc_s.sv
// rtl/mult_acc_s.sv - frame accumulator of signed fractional products with saturated output
import mult_pkg::*;

module mult_acc_s #(
    parameter int NB_DATA  = NB_DATA_DEF,
    parameter int N_TERMS  = 4,
    parameter int NB_GUARD = 3,
    localparam int NB_ACC  = NB_DATA + NB_GUARD,
    localparam int NB_CNT  = $clog2(N_TERMS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_clear,
    input  logic                      i_mult_done,
    input  logic signed [NB_DATA-1:0] i_mult,
    output logic        [NB_ACC-1:0]  o_acc,
    output logic        [NB_DATA-1:0] o_sat,
    output logic                      o_ovf,
    output logic                      o_valid,
    output logic                      o_busy
);

    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(N_TERMS - 1);

    logic signed [NB_ACC-1:0]  acc;
    logic        [NB_CNT-1:0]  count;
    logic signed [NB_ACC-1:0]  mult_ext;
    logic signed [NB_ACC-1:0]  sum;
    logic        [NB_DATA-1:0] sat_w;
    logic                      ovf_w;

    // Sign-extend the product so the binary point stays aligned with the accumulator
    always_comb begin
        mult_ext = NB_ACC'(i_mult);
        sum      = acc + mult_ext;
    end

    sat_q #(
        .NB_DATA (NB_DATA),
        .NB_ACC  (NB_ACC)
    ) u_sat_q (
        .sum (sum),
        .sat (sat_w),
        .ovf (ovf_w)
    );

    assign o_busy = (count != '0);

    // Accumulate strobed products; the last term of a frame publishes the sum and restarts
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc     <= '0;
            count   <= '0;
            o_acc   <= '0;
            o_sat   <= '0;
            o_ovf   <= 1'b0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (i_clear) begin
                acc   <= '0;
                count <= '0;
            end else if (i_mult_done) begin
                if (count == CNT_LAST) begin
                    o_acc   <= sum;
                    o_sat   <= sat_w;
                    o_ovf   <= ovf_w;
                    o_valid <= 1'b1;
                    acc     <= '0;
                    count   <= '0;
                end else begin
                    acc   <= sum;
                    count <= count + NB_CNT'(1);
                end
            end
        end
    end

endmodule

// File: doc/mult_acc_s.md
Name: mult_acc_s

Overview:
Downstream stage of the bit-serial multiplier (multiplier_s). It consumes each product on the multiplier's done strobe and accumulates N_TERMS consecutive signed fractional products in a guard-extended register. It emits a full-precision dot-product result and an NB_DATA-wide saturated copy with a one-cycle valid pulse. It then restarts automatically for the next frame of N_TERMS products.

Parameters:
NB_DATA, 4, product word width, signed Q1.(NB_DATA-1), identical to multiplier_s NB_DATA
N_TERMS, 4, products per frame, must be >= 2
NB_GUARD, 3, extra integer guard bits, must be >= clog2(N_TERMS)+1 so the internal sum never wraps
(localparam) NB_ACC = NB_DATA+NB_GUARD; NB_CNT = clog2(N_TERMS)

Ports:
i_clk  in  1  system clock, all state on rising edge
i_rst  in  1  reset; asynchronous, active-high
i_clear  in  1  synchronous frame abort
i_mult_done  in  1  one-cycle strobe from multiplier; i_mult valid in that cycle
i_mult  in  NB_DATA  signed product Q1.(NB_DATA-1)
o_acc  out  NB_ACC  signed full-precision frame sum Q(NB_GUARD+1).(NB_DATA-1)
o_sat  out  NB_DATA  o_acc saturated to Q1.(NB_DATA-1)
o_ovf  out  1  saturation occurred for the frame presented with o_valid
o_valid  out  1  one-cycle pulse, o_acc/o_sat/o_ovf updated
o_busy  out  1  high while a frame is partially accumulated (count != 0)

Behaviour:
- Reset (async, any time including mid-frame): acc=0, count=0, o_acc=0, o_sat=0, o_ovf=0, o_valid=0, o_busy=0.
- State = (count, acc). ACCUM for count 0..N_TERMS-1. No other FSM states.
- Sample: i_mult sign-extended to NB_ACC bits. Exact addition, no rounding, binary point kept aligned.
- Strobe with count < N_TERMS-1: acc <= acc + ext(i_mult); count++.
- Strobe with count == N_TERMS-1 (last term):
  - o_acc <= acc + ext(i_mult); o_sat and o_ovf are computed from that same sum and registered in the same edge; o_valid <= 1.
  - acc <= 0; count <= 0.
- Latency: o_valid asserts in the cycle after the last strobe's edge, i.e. 1 clock.
- Saturation:
  - sum > 2^(NB_DATA-1)-1 gives o_sat = 0111..1, o_ovf = 1.
  - sum < -2^(NB_DATA-1) gives o_sat = 1000..0, o_ovf = 1.
  - Otherwise o_sat = sum[NB_DATA-1:0], o_ovf = 0.
- o_acc, o_sat and o_ovf hold their values until the next o_valid or reset.
- o_valid is high exactly one cycle per completed frame.
- Back-to-back strobes on every cycle must be accepted without loss. The first strobe of the next frame may coincide with o_valid.
- i_clear: acc <= 0, count <= 0, no o_valid, outputs retain their last frame values. It takes priority over a simultaneous i_mult_done, whose sample is discarded.
- i_mult is ignored when i_mult_done = 0.
- o_busy = (count != 0), combinational from the register.

Decomposition:
- Shared package mult_pkg: NB_DATA default, Q-format constants QMAX/QMIN for NB_DATA, and a saturate function (NB_ACC to NB_DATA plus ovf flag). multiplier_s and this block share the package.
- One natural sub-module: sat_q, the combinational saturator with inputs sum/NB_ACC and outputs sat/NB_DATA and ovf. The rest is a single module.

Test Plan:
- Reset release, then products 1100, 0010, 0001, 1111 (-0.5, +0.25, +0.125, -0.125) -> one o_valid one cycle after 4th strobe; o_acc=1111110 (-0.25), o_sat=1110, o_ovf=0; o_busy 1 after first strobe, 0 after last.
- Four strobes of 0011 (+0.375) -> o_acc=0001100 (+1.5), o_sat=0111, o_ovf=1.
- Four strobes of 1000 (-1.0), back-to-back every cycle -> o_acc=1100000 (-4.0), o_sat=1000, o_ovf=1; no sample lost.
- Two strobes of 0100, then i_clear coincident with a third strobe of 0100, then four strobes of 0001 -> single o_valid with o_acc=0000100 (+0.5), o_sat=0100, o_ovf=0; previous outputs held until then.
- Async i_rst pulsed between strobes mid-frame (after 2 of 4 terms) -> all outputs 0 immediately without a clock edge; the next four strobes form a fresh frame.
- Eight consecutive strobes (two frames, each the first-scenario values), with the 5th strobe coinciding with frame-1 o_valid -> exactly two o_valid pulses, both with o_acc=1111110.
